// File: rtl/piso_sipo_pkg.sv
// Shared definitions for the PISO/SIPO serial link: FSM state type,
// default word width and the frame-bit counter width helper.
package piso_sipo_pkg;

    // Default data word width, common to both ends of the link.
    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Counter wide enough for WIDTH data bits plus an optional parity bit.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame-bit counter for the PISO transmitter. Counts 0..FRAME_LEN-1 while
// enabled, returns to 0 after the last bit, and can be cleared at any time
// when a new word is loaded. last_o flags the final bit of the frame.
module piso_bit_counter
    import piso_sipo_pkg::*;
#(
    parameter int FRAME_LEN = DATA_W,
    parameter int CW        = cnt_width(DATA_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last_o = (cnt_q == LAST_IDX);
    assign cnt_o  = cnt_q;

    // Next count: clear on load, wrap to 0 after the last bit, never count past it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : (cnt_q + CW'(1));
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a
// valid/ready handshake and sends it one bit per clock on serial_out with
// serial_valid / frame_start strobes. A word offered during the last bit
// cycle is loaded immediately so back-to-back frames have no idle gap.
// Optional build macro PISO_PARITY_EN appends an even-parity bit to every
// frame (frame length WIDTH+1).
module piso_serializer
    import piso_sipo_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = cnt_width(WIDTH);

    piso_state_e      state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             serial_out_q;
    logic             serial_valid_q;
    logic             frame_start_q;
    logic             busy_q;
    logic             out_bit_d;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    // Ready in IDLE, or in SHIFT while the final bit of the frame is going out.
    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && last_bit));
    assign accept   = in_valid && in_ready;

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign frame_start  = frame_start_q;
    assign busy         = busy_q;

    piso_bit_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CW        (CW)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept),
        .inc_i  (state_q == SHIFT),
        .cnt_o  (bit_cnt),
        .last_o (last_bit)
    );

    // Select the outgoing bit and the shifted register image (zero fill).
    always_comb begin
        if (MSB_FIRST != 0) begin
            out_bit_d = shreg_q[WIDTH-1];
            shreg_d   = shreg_q << 1;
        end else begin
            out_bit_d = shreg_q[0];
            shreg_d   = shreg_q >> 1;
        end
`ifdef PISO_PARITY_EN
        // Data bits are exhausted; the trailing bit is the stored parity.
        if (bit_cnt == CW'(WIDTH)) begin
            out_bit_d = parity_q;
        end
`endif
    end

    // Transmit FSM with registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            busy_q         <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    serial_out_q   <= 1'b0;
                    serial_valid_q <= 1'b0;
                    frame_start_q  <= 1'b0;
                    busy_q         <= 1'b0;
                    if (accept) begin
                        shreg_q <= parallel_in;
`ifdef PISO_PARITY_EN
                        parity_q <= ^parallel_in;
`endif
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    serial_out_q   <= out_bit_d;
                    serial_valid_q <= 1'b1;
                    frame_start_q  <= (bit_cnt == '0);
                    busy_q         <= 1'b1;
                    shreg_q        <= shreg_d;
                    if (last_bit) begin
                        if (accept) begin
                            // Reload so the next frame follows without a gap.
                            shreg_q <= parallel_in;
`ifdef PISO_PARITY_EN
                            parity_q <= ^parallel_in;
`endif
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
`timescale 1ns/1ps
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         in_valid = 1'b1;
    logic [W-1:0] parallel_in = '0;

    logic rdy_m, so_m, sv_m, fs_m, busy_m;
    logic rdy_l, so_l, sv_l, fs_l, busy_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .parallel_in(parallel_in), .in_valid(in_valid),
        .in_ready(rdy_m), .serial_out(so_m), .serial_valid(sv_m),
        .frame_start(fs_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .parallel_in(parallel_in), .in_valid(in_valid),
        .in_ready(rdy_l), .serial_out(so_l), .serial_valid(sv_l),
        .frame_start(fs_l), .busy(busy_l)
    );

    // Reference model: a queue of bits still to appear on the line, one entry
    // per future clock. Both bit orders are tracked side by side.
    typedef struct {
        logic m;
        logic l;
        logic first;
    } bit_t;

    bit_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_m = 1'b0, exp_l = 1'b0, exp_sv = 1'b0, exp_fs = 1'b0;
    logic acc = 1'b0;

    // A word can be taken when at most the final bit of the current frame is pending.
    function automatic logic model_ready();
        return !rst && (q.size() <= 1);
    endfunction

    function automatic void push_frame(input logic [W-1:0] w);
        bit_t e;
        for (int j = 0; j < W; j++) begin
            e.m = w[W-1-j];
            e.l = w[j];
            e.first = (j == 0);
            q.push_back(e);
        end
`ifdef PISO_PARITY_EN
        e.m = ^w;
        e.l = ^w;
        e.first = 1'b0;
        q.push_back(e);
`endif
    endfunction

    task automatic tick();
        bit_t e;
        logic r;
        @(posedge clk);
        r   = model_ready();
        acc = in_valid && r;
        if (rst) begin
            q.delete();
            {exp_m, exp_l, exp_sv, exp_fs} = 4'b0000;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                exp_m = e.m; exp_l = e.l; exp_sv = 1'b1; exp_fs = e.first;
            end else begin
                {exp_m, exp_l, exp_sv, exp_fs} = 4'b0000;
            end
            if (acc) push_frame(parallel_in);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; parallel_in = 8'hE8;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (rdy_m !== 1'b0 || rdy_l !== 1'b0) begin
                n_fail++; $display("FAIL reset_ready: got %b%b expected 00", rdy_m, rdy_l);
            end
            tick();
            n_tests++;
            if ({so_m, sv_m, fs_m, busy_m, so_l, sv_l, fs_l, busy_l} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b%b%b%b %b%b%b%b expected all 0",
                         so_m, sv_m, fs_m, busy_m, so_l, sv_l, fs_l, busy_l);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    // Send one word and compare the collected stream with fixed expectations.
    task automatic test_word(input logic [W-1:0] w, input logic [FL-1:0] want_m,
                             input logic [FL-1:0] want_l, input string tag);
        logic [FL-1:0] got_m = '0, got_l = '0;
        int nv = 0, nfs = 0, c = 0;
        logic fs_ok = 1'b1;
        in_valid = 1'b1; parallel_in = w;
        acc = 1'b0;
        for (c = 0; c < FL + 5 && !acc; c++) tick();
        n_tests++;
        if (!acc) begin
            n_fail++; $display("FAIL %s_accept: got no handshake expected one", tag);
        end
        in_valid = 1'b0; parallel_in = $urandom();
        for (int k = 0; k < FL + 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (rdy_m !== model_ready() || rdy_l !== model_ready()) begin
                n_fail++; $display("FAIL %s_ready: got %b%b expected %b", tag, rdy_m, rdy_l, model_ready());
            end
            tick();
            n_tests++;
            if ({so_m, sv_m, fs_m, busy_m} !== {exp_m, exp_sv, exp_fs, exp_sv} ||
                {so_l, sv_l, fs_l, busy_l} !== {exp_l, exp_sv, exp_fs, exp_sv}) begin
                n_fail++;
                $display("FAIL %s_cycle%0d: got m=%b%b%b%b l=%b%b%b%b expected m=%b l=%b sv=%b fs=%b",
                         tag, k, so_m, sv_m, fs_m, busy_m, so_l, sv_l, fs_l, busy_l, exp_m, exp_l, exp_sv, exp_fs);
            end
            if (sv_m) begin
                got_m = {got_m[FL-2:0], so_m};
                got_l = {got_l[FL-2:0], so_l};
                if (fs_m) begin
                    nfs++;
                    if (nv != 0) fs_ok = 1'b0;
                end
                nv++;
            end
        end
        n_tests++;
        if (got_m !== want_m || got_l !== want_l) begin
            n_fail++; $display("FAIL %s_stream: got %b/%b expected %b/%b", tag, got_m, got_l, want_m, want_l);
        end
        n_tests++;
        if (nv != FL || nfs != 1 || !fs_ok) begin
            n_fail++; $display("FAIL %s_strobes: got valid=%0d starts=%0d expected valid=%0d starts=1 on first bit",
                               tag, nv, nfs, FL);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] stream = '0;
        logic [31:0] want;
        int wi = 0, nv = 0, nrdy = 0;
        logic gap = 1'b0;
        int fs_pos[$];
        for (int k = 0; k < 2 * FL + 8; k++) begin
            in_valid = (wi < 2);
            parallel_in = (wi == 0) ? 8'hA5 : 8'h3C;
            @(negedge clk);
            n_tests++;
            if (rdy_m !== model_ready() || rdy_l !== model_ready()) begin
                n_fail++; $display("FAIL b2b_ready: got %b%b expected %b", rdy_m, rdy_l, model_ready());
            end
            if (wi == 1 && rdy_m) nrdy++;
            tick();
            if (acc) wi++;
            n_tests++;
            if ({so_m, sv_m, fs_m, busy_m} !== {exp_m, exp_sv, exp_fs, exp_sv} ||
                {so_l, sv_l, fs_l, busy_l} !== {exp_l, exp_sv, exp_fs, exp_sv}) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got m=%b%b%b%b l=%b%b%b%b expected m=%b l=%b sv=%b fs=%b",
                         k, so_m, sv_m, fs_m, busy_m, so_l, sv_l, fs_l, busy_l, exp_m, exp_l, exp_sv, exp_fs);
            end
            if (sv_m) begin
                if (fs_m) fs_pos.push_back(nv);
                stream = {stream[30:0], so_m};
                nv++;
            end else if (nv > 0 && nv < 2 * FL) begin
                gap = 1'b1;
            end
        end
        in_valid = 1'b0;
`ifdef PISO_PARITY_EN
        want = {14'b0, 8'hA5, 1'b0, 8'h3C, 1'b0};
`else
        want = {16'b0, 16'hA53C};
`endif
        n_tests++;
        if (stream !== want || nv != 2 * FL || gap) begin
            n_fail++; $display("FAIL b2b_stream: got %h valid=%0d gap=%b expected %h valid=%0d gap=0",
                               stream, nv, gap, want, 2 * FL);
        end
        n_tests++;
        if (fs_pos.size() != 2 || fs_pos[0] != 0 || fs_pos[1] != FL || nrdy != 1) begin
            n_fail++; $display("FAIL b2b_framing: got starts=%0d ready_cycles=%0d expected starts at 0,%0d ready_cycles=1",
                               fs_pos.size(), nrdy, FL);
        end
    endtask

    task automatic test_reset_mid_frame();
        in_valid = 1'b1; parallel_in = 8'hFF;
        acc = 1'b0;
        for (int c = 0; c < 4 && !acc; c++) tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        n_tests++;
        if (sv_m !== 1'b1 || so_m !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got so=%b sv=%b expected so=1 sv=1", so_m, sv_m);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rdy_m !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ready: got %b expected 0", rdy_m);
        end
        tick();
        n_tests++;
        if ({so_m, sv_m, fs_m, busy_m, so_l, sv_l, fs_l, busy_l} !== 8'h00) begin
            n_fail++; $display("FAIL midrst_abort: got %b%b%b%b %b%b%b%b expected all 0",
                               so_m, sv_m, fs_m, busy_m, so_l, sv_l, fs_l, busy_l);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (sv_m !== 1'b0 || so_m !== 1'b0) begin
            n_fail++; $display("FAIL midrst_noresume: got so=%b sv=%b expected 0 0", so_m, sv_m);
        end
`ifdef PISO_PARITY_EN
        test_word(8'h01, {8'h01, 1'b1}, {8'h80, 1'b1}, "after_rst");
`else
        test_word(8'h01, 8'h01, 8'h80, "after_rst");
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (rst || acc || !in_valid) begin
                parallel_in = $urandom();
                in_valid = ($urandom_range(0, 9) < 7);
            end
            rst = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            n_tests++;
            if (rdy_m !== model_ready() || rdy_l !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready%0d: got %b%b expected %b", k, rdy_m, rdy_l, model_ready());
            end
            tick();
            n_tests++;
            if ({so_m, sv_m, fs_m, busy_m} !== {exp_m, exp_sv, exp_fs, exp_sv} ||
                {so_l, sv_l, fs_l, busy_l} !== {exp_l, exp_sv, exp_fs, exp_sv}) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: got m=%b%b%b%b l=%b%b%b%b expected m=%b l=%b sv=%b fs=%b",
                         k, so_m, sv_m, fs_m, busy_m, so_l, sv_l, fs_l, busy_l, exp_m, exp_l, exp_sv, exp_fs);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < FL + 2; k++) tick();
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        test_word(8'h07, {8'h07, 1'b1}, {8'hE0, 1'b1}, "parity07");
        test_word(8'h03, {8'h03, 1'b0}, {8'hC0, 1'b0}, "parity03");
    endtask
`endif

    initial begin
        test_reset();
`ifdef PISO_PARITY_EN
        test_word(8'hE8, {8'hE8, 1'b0}, {8'h17, 1'b0}, "single");
        test_parity();
`else
        test_word(8'hE8, 8'hE8, 8'h17, "single");
`endif
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter, the transmit-side counterpart of the SIPO receiver in the PISO_SIPO block.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per clock on serial_out, with qualifying strobes so the SIPO end can frame words.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8: data word width in bits; legal range 2 or more.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- parallel_in  input  WIDTH  word to transmit; sampled only on handshake.
- in_valid  input  1  parallel_in holds a valid word.
- in_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  registered serial data.
- serial_valid  output  1  serial_out carries a frame bit this cycle.
- frame_start  output  1  high only during the first bit of each frame.
- busy  output  1  frame in progress.

Behaviour:
- One clock, synchronous active-high reset `rst`, clock `clk`.
- Reset values: serial_out=0, serial_valid=0, frame_start=0, busy=0, shift register=0, bit counter=0, FSM=IDLE.
- While rst=1, in_ready=0. rst asserted mid-frame aborts the frame immediately; the partial word is discarded and nothing is resumed.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch parallel_in into the shift register and go to SHIFT.
  - SHIFT: emit one bit per cycle; the bit counter counts 0..FRAME_LEN-1.
  - FRAME_LEN = WIDTH, or WIDTH+1 when parity is compiled in.
- Latency: a word accepted at edge k drives its first bit on serial_out from edge k+1. The last bit is driven from edge k+FRAME_LEN.
- in_ready is combinational: high in IDLE, and high in SHIFT during the last bit cycle.
  - Handshake in the last bit cycle: reload, reset counter, stay in SHIFT. The next frame's first bit follows with no gap.
  - Last bit with no handshake: go to IDLE; serial_valid=0 next cycle.
- serial_valid=1 for every frame bit cycle.
- frame_start=1 only in the cycle carrying bit 0 of the frame, including back-to-back frames.
- busy=1 whenever serial_valid=1.
- Bit order follows MSB_FIRST. The shift register shifts left (MSB_FIRST=1) or right (0), filling with 0.
- in_valid while in_ready=0 is ignored. The source must hold the word; the block does no buffering.
- Between frames serial_out holds 0.
- Counter width is $clog2(WIDTH+2). No wrap beyond FRAME_LEN-1.

Optional Feature:
- Macro PISO_PARITY_EN.
- When defined:
  - An even-parity bit (XOR of all WIDTH data bits, computed at load) is appended after the last data bit.
  - serial_valid stays high for that bit and FRAME_LEN=WIDTH+1.
  - The in_ready back-to-back window moves to the parity cycle.
- When undefined: no parity logic, FRAME_LEN=WIDTH.

Decomposition:
- Package piso_sipo_pkg:
  - FSM state typedef (IDLE, SHIFT).
  - Default width constant DATA_W=8, shared with the SIPO.
  - Counter-width function.
- One natural sub-module, piso_bit_counter: loadable frame-bit counter with a last-bit flag.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0; serial_out, serial_valid, frame_start, busy all 0.
- Single word: parallel_in=8'hE8, MSB_FIRST=1 -> serial_out 1,1,1,0,1,0,0,0 over 8 cycles starting the cycle after the handshake. frame_start high on the first bit only; serial_valid high for exactly 8 cycles.
- LSB order: MSB_FIRST=0, parallel_in=8'hE8 -> serial_out 0,0,0,1,0,1,1,1.
- Back-to-back: 8'hA5, then 8'h3C presented continuously -> 16 contiguous valid bits 10100101 00111100. frame_start pulses on bits 1 and 9; in_ready high only in bit-8 cycle.
- Reset mid-frame: 8'hFF, assert rst after 3 bits -> next cycle serial_out=0, serial_valid=0. After release, 8'h01 transmits cleanly as 00000001.
- With PISO_PARITY_EN defined: 8'h07 -> 00000111 then parity bit 1; serial_valid high for 9 cycles. With 8'h03, parity bit is 0.
